// File: rtl/mips_pkg.sv
// Opcodes and pipeline constants shared by the fetch stage and the hazard logic.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [31:0] NOP_WORD = 32'b0;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } fetch_state_t;

   function automatic logic [5:0] opcode_of(input logic [31:0] word);
      return word[31:26];
   endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register, branch/jump squash,
// HALT freeze and saturating stall/flush counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16,
   parameter logic [5:0]  HALT_OP  = OP_HALT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      pc,
   output logic [31:0]      instructionID,
   output logic [31:0]      pcplus4ID,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  instr_reg;
   logic [31:0]  pcplus4_reg;
   logic         halted_reg;

   logic [5:0]   id_op;
   logic         in_run;
   logic         is_halt_id;
   logic         is_jump_id;
   logic [31:0]  br_target_aligned;
   logic [31:0]  jump_target;

   assign id_op             = opcode_of(instr_reg);
   assign in_run            = (state_reg == ST_RUN);
   assign is_halt_id        = (id_op == HALT_OP);
   assign is_jump_id        = !is_halt_id && (id_op == OP_J);
   assign br_target_aligned = br_target & ~32'h3;
   assign jump_target       = {pcplus4_reg[31:28], instr_reg[25:0], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_RUN;
         pc_reg      <= RESET_PC;
         instr_reg   <= NOP_WORD;
         pcplus4_reg <= NOP_WORD;
         halted_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_RUN: begin
               // A taken branch beats a stall: the stalled ID word is wrong-path.
               if (br_taken) begin
                  pc_reg      <= br_target_aligned;
                  instr_reg   <= NOP_WORD;
                  pcplus4_reg <= NOP_WORD;
               end else if (stall) begin
                  pc_reg <= pc_reg;
               end else if (is_halt_id) begin
                  instr_reg  <= NOP_WORD;
                  halted_reg <= 1'b1;
                  state_reg  <= ST_HALTED;
               end else if (is_jump_id) begin
                  pc_reg      <= jump_target;
                  instr_reg   <= NOP_WORD;
                  pcplus4_reg <= NOP_WORD;
               end else begin
                  instr_reg   <= imem_rdata;
                  pcplus4_reg <= pc_reg + PC_STEP;
                  pc_reg      <= pc_reg + PC_STEP;
               end
            end
            ST_HALTED: begin
               instr_reg <= NOP_WORD;
               // An older branch still in EX may pull fetch out of HALT.
               if (br_taken) begin
                  pc_reg     <= br_target_aligned;
                  halted_reg <= 1'b0;
                  state_reg  <= ST_RUN;
               end
            end
            default: begin
               state_reg <= ST_RUN;
            end
         endcase
      end
   end

   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   assign cnt_inc[0] = in_run && !br_taken && stall;
   assign cnt_inc[1] = in_run && (br_taken || (!stall && is_jump_id));

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
         );
      end
   endgenerate

   assign stall_cnt     = cnt_val[0];
   assign flush_cnt     = cnt_val[1];
   assign imem_addr     = pc_reg;
   assign pc            = pc_reg;
   assign instructionID = instr_reg;
   assign pcplus4ID     = pcplus4_reg;
   assign halted        = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random stimulus
// against a behavioural pipeline model.
module tb_fetch_stage;

   localparam int CW      = 4;
   localparam int SAT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          br_taken = 1'b0;
   logic [31:0]   br_target = 32'h0;
   logic [31:0]   imem_addr, imem_rdata, pc, instructionID, pcplus4ID;
   logic          halted;
   logic [CW-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   assign imem_rdata = mem[imem_addr[7:2]];

   fetch_stage #(.RESET_PC(32'h0), .CNT_W(CW), .HALT_OP(6'b111111)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .instructionID (instructionID),
      .pcplus4ID     (pcplus4ID),
      .halted        (halted),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   typedef struct {
      int          due;
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] p4;
      logic        h;
      int          sc;
      int          fc;
   } exp_t;

   exp_t  sbq[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   string phase = "reset";

   // behavioural model state
   logic [31:0] m_pc, m_ir, m_p4;
   logic        m_h;
   int          m_sc, m_fc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_reset();
      m_pc = 32'h0; m_ir = 32'h0; m_p4 = 32'h0; m_h = 1'b0; m_sc = 0; m_fc = 0;
   endtask

   function automatic int sat_inc(input int v);
      return (v < SAT_MAX) ? v + 1 : v;
   endfunction

   // Drive one cycle of inputs, predict the state after the next edge, wait for it.
   task automatic step(input logic s, input logic b, input logic [31:0] t);
      exp_t e;
      stall = s; br_taken = b; br_target = t;
      if (m_h) begin
         m_ir = 32'h0;
         if (b) begin m_pc = t & 32'hFFFF_FFFC; m_h = 1'b0; end
      end else if (b) begin
         m_pc = t & 32'hFFFF_FFFC; m_ir = 32'h0; m_p4 = 32'h0; m_fc = sat_inc(m_fc);
      end else if (s) begin
         m_sc = sat_inc(m_sc);
      end else if (m_ir[31:26] == 6'b111111) begin
         m_ir = 32'h0; m_h = 1'b1;
      end else if (m_ir[31:26] == 6'b000010) begin
         m_pc = {m_p4[31:28], m_ir[25:0], 2'b00}; m_ir = 32'h0; m_p4 = 32'h0;
         m_fc = sat_inc(m_fc);
      end else begin
         m_ir = mem[m_pc[7:2]]; m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end
      e.due = cyc + 1; e.pc = m_pc; e.ir = m_ir; e.p4 = m_p4; e.h = m_h;
      e.sc = m_sc; e.fc = m_fc;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (pc !== 32'h0 || imem_addr !== 32'h0 || instructionID !== 32'h0 ||
          pcplus4ID !== 32'h0 || halted !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
         errors++;
         $display("FAIL %s: pc=%h ir=%h p4=%h halted=%b sc=%0d fc=%0d, required all zero",
                  name, pc, instructionID, pcplus4ID, halted, stall_cnt, flush_cnt);
      end else begin
         $display("check %s: reset values ok", name);
      end
   endtask

   // Called at posedge+1; asserts reset mid-cycle and checks without any clock edge.
   task automatic async_reset();
      #4;
      sbq.delete();
      stall = 1'b0; br_taken = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // monitor: compares every cycle whose prediction is due
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (pc !== e.pc || imem_addr !== e.pc || instructionID !== e.ir ||
                pcplus4ID !== e.p4 || halted !== e.h ||
                int'(stall_cnt) != e.sc || int'(flush_cnt) != e.fc) begin
               errors++;
               $display("FAIL %s cyc%0d: got pc=%h addr=%h ir=%h p4=%h h=%b sc=%0d fc=%0d required pc=%h ir=%h p4=%h h=%b sc=%0d fc=%0d",
                        phase, cyc, pc, imem_addr, instructionID, pcplus4ID, halted,
                        stall_cnt, flush_cnt, e.pc, e.ir, e.p4, e.h, e.sc, e.fc);
            end else begin
               $display("check %s cyc%0d: pc=%h ir=%h p4=%h h=%b sc=%0d fc=%0d",
                        phase, cyc, pc, instructionID, pcplus4ID, halted, stall_cnt, flush_cnt);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [31:0] r;
      for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;

      mem[4] = 32'h8C22_0004;
      phase = "seq";
      repeat (5) step(1'b0, 1'b0, 32'h0);

      phase = "stall";
      repeat (3) step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);

      phase = "branch";
      step(1'b1, 1'b1, 32'h0000_0043);
      repeat (2) step(1'b0, 1'b0, 32'h0);

      phase = "jump";
      mem[1] = 32'h0800_0010;
      step(1'b0, 1'b1, 32'h1000_0004);
      repeat (3) step(1'b0, 1'b0, 32'h0);

      phase = "halt";
      mem[8] = 32'hFC00_0000;
      step(1'b0, 1'b1, 32'h0000_0020);
      repeat (2) step(1'b0, 1'b0, 32'h0);
      repeat (10) step(1'($urandom_range(1)), 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0080);
      repeat (3) step(1'b0, 1'b0, 32'h0);

      phase = "rst";
      repeat (2) step(1'b1, 1'b0, 32'h0);
      async_reset();

      phase = "sat";
      repeat (20) step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);

      phase = "wrap";
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      repeat (3) step(1'b0, 1'b0, 32'h0);

      phase = "random";
      for (int i = 0; i < 64; i++) begin
         r = $urandom;
         k = $urandom_range(19);
         if (k < 2) r[31:26] = 6'b000010;
         else if (k == 2) r[31:26] = 6'b111111;
         mem[i] = r;
      end
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(3) == 0), 1'($urandom_range(11) == 0), $urandom);
      end
      stall = 1'b0; br_taken = 1'b0;
      repeat (2) @(posedge clk);
      #5;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d predictions left unchecked, required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Sits directly upstream of the data-hazard stall detector.
- Owns the PC, drives the instruction-memory address and supplies instructionID and its PC+4 to decode.
- Consumes the stall detector's stall output and the EX-stage branch resolution; squashes on redirect, freezes on HALT, and keeps saturating stall/flush counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the stall and flush performance counters.
- HALT_OP, 6'b111111, opcode that halts fetch when it reaches ID.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold request from the data-hazard stall detector.
- br_taken  input  1  branch resolved taken in EX (beq/bne).
- br_target  input  32  branch target address from EX.
- imem_addr  output  32  instruction-memory read address (equal to pc).
- imem_rdata  input  32  instruction word; combinational read of imem_addr, same cycle.
- pc  output  32  current fetch PC.
- instructionID  output  32  IF/ID instruction register; 32'b0 is a bubble.
- pcplus4ID  output  32  PC+4 of the instruction held in instructionID.
- halted  output  1  fetch frozen by HALT.
- stall_cnt  output  CNT_W  cycles in which the stall hold was applied; saturating.
- flush_cnt  output  CNT_W  cycles in which a branch or jump squash occurred; saturating.

Behaviour:
- Reset: asynchronous on rst_n low. pc=RESET_PC, instructionID=0, pcplus4ID=0, halted=0, stall_cnt=0, flush_cnt=0, state=RUN.
- imem_addr = pc, combinational.
- pc[1:0] are always 00; br_target[1:0] and jump-target low bits are forced to 00.
- No branch delay slot: wrong-path instructions are squashed to 32'b0.
- State machine, RUN: evaluate the following each cycle in priority order.
  1. br_taken: pc<=br_target; instructionID<=0; pcplus4ID<=0; flush_cnt++.
  2. stall: pc, instructionID and pcplus4ID all hold; stall_cnt++.
  3. instructionID[31:26]==HALT_OP: instructionID<=0; pc holds; halted<=1; next state HALTED.
  4. instructionID[31:26]==6'b000010 (jump): pc<={pcplus4ID[31:28], instructionID[25:0], 2'b00}; instructionID<=0; pcplus4ID<=0; flush_cnt++.
  5. Otherwise: instructionID<=imem_rdata; pcplus4ID<=pc+4; pc<=pc+4.
- State machine, HALTED:
  - pc holds; instructionID=0 every cycle; halted=1.
  - br_taken still redirects: pc<=br_target, halted<=0, next state RUN. This covers an older branch still in flight when HALT was decoded.
  - The only other exit is reset.
- Simultaneous events:
  - br_taken with stall: the branch wins, because the stalled ID instruction is on the wrong path. flush_cnt increments; stall_cnt does not.
  - stall with a jump in ID: the stall wins and the jump is taken on the first non-stall cycle.
- Latency: an instruction fetched in cycle N appears on instructionID in cycle N+1. Branch redirect penalty is 1 fetch bubble plus the ID squash; jump penalty is 1 bubble.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 gives 0. Counters stick at all-ones and never wrap.
- Reset asserted mid-stall or mid-halt clears all state immediately, without waiting for a clock edge.

Decomposition:
- Shared package (mips_pkg):
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE, OP_HALT;
  - NOP_WORD = 32'b0;
  - PC_STEP = 4.
- The same opcode constants are used by the stall detector.
- One sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output count). Instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Sequential fetch: reset, imem returns addr-dependent words, no stall/branch. pc goes 0,4,8,C; instructionID lags imem_rdata by one cycle; pcplus4ID = fetch PC+4.
- Stall hold: assert stall for 3 cycles while instructionID=32'h8C220004. pc, instructionID and pcplus4ID are frozen for 3 cycles; stall_cnt=3; fetch resumes at the held pc.
- Branch flush: br_taken=1, br_target=32'h0000_0040, stall also high. Next cycle pc=0x40 and instructionID=0; flush_cnt=1, stall_cnt unchanged; the word at 0x40 reaches ID one cycle later.
- Jump: instructionID=32'h0800_0010 with pcplus4ID=32'h1000_0008. Next pc=32'h1000_0040, instructionID=0, flush_cnt++.
- Halt: 32'hFC00_0000 reaches ID. halted=1, instructionID stays 0 and pc is frozen for 10 cycles. A later br_taken to 0x80 clears halted and fetches from 0x80.
- Reset and saturation:
  - Pulse rst_n low mid-stall: all outputs return to reset values asynchronously.
  - Force more than 2^CNT_W stall cycles (CNT_W=4 in the bench): stall_cnt holds at 4'hF.
